// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone memory master.
package wb_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  localparam logic [3:0] SEL_BYTE = 4'b0001;
  localparam logic [3:0] SEL_HALF = 4'b0011;
  localparam logic [3:0] SEL_WORD = 4'b1111;

  // Request attributes kept for the read-extract step after the bus cycle.
  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       uns;
    logic [1:0] addr_lo;
  } req_t;

endpackage

// File: rtl/wb_mem_master_if.sv
// CPU request port plus Wishbone master port of the memory master.
interface wb_mem_master_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            req_i;
  logic            we_i;
  logic [XLEN-1:0] addr_i;
  logic [1:0]      size_i;
  logic            unsigned_i;
  logic [XLEN-1:0] wdata_i;
  logic            busy_o;
  logic            done_o;
  logic            err_o;
  logic [XLEN-1:0] rdata_o;

  logic [XLEN-1:0] adr_o;
  logic [XLEN-1:0] dat_o;
  logic [3:0]      sel_o;
  logic            we_o;
  logic            cyc_o;
  logic            stb_o;
  logic [XLEN-1:0] dat_i;
  logic            ack_i;
  logic            err_i;

  modport master (
    input  req_i, we_i, addr_i, size_i, unsigned_i, wdata_i, dat_i, ack_i, err_i,
    output busy_o, done_o, err_o, rdata_o, adr_o, dat_o, sel_o, we_o, cyc_o, stb_o
  );

  modport slave (
    output req_i, we_i, addr_i, size_i, unsigned_i, wdata_i, dat_i, ack_i, err_i,
    input  busy_o, done_o, err_o, rdata_o, adr_o, dat_o, sel_o, we_o, cyc_o, stb_o
  );
endinterface

// File: rtl/wb_lane_mux.sv
// Byte-lane logic: sel generation, write replication, read extract/extend, alignment check.
module wb_lane_mux
  import wb_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  size_e           size,
  input  logic [1:0]      addr_lo,
  input  logic            uns,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata_raw,
  output logic [3:0]      sel_c,
  output logic [XLEN-1:0] wdata_c,
  output logic [XLEN-1:0] rdata_c,
  output logic            misaligned_c
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    sel_c        = SEL_WORD;
    wdata_c      = wdata;
    rdata_c      = rdata_raw;
    misaligned_c = 1'b0;
    shifted      = rdata_raw >> {addr_lo, 3'b000};
    case (size)
      SIZE_BYTE: begin
        sel_c   = SEL_BYTE << addr_lo;
        wdata_c = {4{wdata[7:0]}};
        rdata_c = uns ? XLEN'(shifted[7:0]) : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      end
      SIZE_HALF: begin
        misaligned_c = addr_lo[0];
        sel_c        = SEL_HALF << {addr_lo[1], 1'b0};
        wdata_c      = {2{wdata[15:0]}};
        rdata_c      = uns ? XLEN'(shifted[15:0]) : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      end
      default: misaligned_c = (addr_lo != 2'b00);
    endcase
  end

endmodule

// File: rtl/wb_mem_master.sv
// CPU load/store to Wishbone master bridge; define WB_MEM_MASTER_TIMEOUT_EN for a bus-wait timeout.
module wb_mem_master
  import wb_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic             clk_i,
  input logic             rst_i,
  wb_mem_master_if.master bus
);

  state_e          state_q, state_d;
  req_t            req_q, req_d;
  logic            cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [XLEN-1:0] adr_q, adr_d, dat_q, dat_d, rdata_q, rdata_d;
  logic [3:0]      sel_q, sel_d;
  logic            done_q, done_d, err_q, err_d, busy_q, busy_d;
  logic            timeout_c;
  logic            bus_end_c;

  size_e           mux_size;
  logic [1:0]      mux_lo;
  logic            mux_uns;
  logic [3:0]      sel_c;
  logic [XLEN-1:0] wdata_c, rdata_c;
  logic            misaligned_c;

  // Live request decides lanes in IDLE; the captured request drives read extraction afterwards.
  always_comb begin
    if (state_q == ST_IDLE) begin
      mux_size = size_e'(bus.size_i);
      mux_lo   = bus.addr_i[1:0];
      mux_uns  = bus.unsigned_i;
    end else begin
      mux_size = size_e'(req_q.size);
      mux_lo   = req_q.addr_lo;
      mux_uns  = req_q.uns;
    end
  end

  wb_lane_mux #(.XLEN(XLEN)) u_lane_mux (
    .size         (mux_size),
    .addr_lo      (mux_lo),
    .uns          (mux_uns),
    .wdata        (bus.wdata_i),
    .rdata_raw    (bus.dat_i),
    .sel_c        (sel_c),
    .wdata_c      (wdata_c),
    .rdata_c      (rdata_c),
    .misaligned_c (misaligned_c)
  );

`ifdef WB_MEM_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] tmo_q;

  // Zero whenever outside BUS, so it restarts on every BUS entry.
  always_ff @(posedge clk_i) begin
    if (rst_i || state_q != ST_BUS) tmo_q <= '0;
    else                            tmo_q <= tmo_q + CNT_W'(1);
  end

  assign timeout_c = (state_q == ST_BUS) && (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo_c;
  assign unused_tmo_c = (TIMEOUT_CYCLES == 0);
  assign timeout_c    = 1'b0;
`endif

  assign bus_end_c = bus.ack_i || bus.err_i || timeout_c;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.req_i) state_d = misaligned_c ? ST_RESP : ST_BUS;
      ST_BUS:  if (bus_end_c) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of all registered outputs; err_i overrides a simultaneous ack_i.
  always_comb begin
    req_d   = req_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    busy_d  = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (bus.req_i) begin
          req_d = '{we: bus.we_i, size: bus.size_i, uns: bus.unsigned_i, addr_lo: bus.addr_i[1:0]};
          if (misaligned_c) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            cyc_d = 1'b1;
            stb_d = 1'b1;
            we_d  = bus.we_i;
            adr_d = {bus.addr_i[XLEN-1:2], 2'b00};
            dat_d = wdata_c;
            sel_d = sel_c;
          end
        end
      end
      ST_BUS: begin
        if (bus_end_c) begin
          cyc_d  = 1'b0;
          stb_d  = 1'b0;
          we_d   = 1'b0;
          sel_d  = '0;
          done_d = 1'b1;
          err_d  = bus.err_i || !bus.ack_i;
          if (!err_d && !req_q.we) rdata_d = rdata_c;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_q   <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      req_q   <= req_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.cyc_o   = cyc_q;
  assign bus.stb_o   = stb_q;
  assign bus.we_o    = we_q;
  assign bus.adr_o   = adr_q;
  assign bus.dat_o   = dat_q;
  assign bus.sel_o   = sel_q;
  assign bus.rdata_o = rdata_q;
  assign bus.done_o  = done_q;
  assign bus.err_o   = err_q;
  assign bus.busy_o  = busy_q;

endmodule

// File: tb/tb_wb_mem_master.sv
// Scoreboard bench for wb_mem_master: directed accesses, responses checked by a done_o monitor.
module tb_wb_mem_master;
  import wb_pkg::*;

  localparam int unsigned TMO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_mem_master_if #(.XLEN(32)) bus ();

  wb_mem_master #(.XLEN(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Response monitor: every done_o pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.done_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done_o=1 with no access outstanding");
      end else begin
        mon_e = sb_q.pop_front();
        check("resp_err", 32'(bus.err_o), 32'(mon_e.err));
        check("resp_rdata", bus.rdata_o, mon_e.rdata);
      end
    end
  end

  task automatic access(input string name, input logic we, input logic [31:0] addr,
                        input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                        input logic [31:0] rd, input int dly, input logic berr,
                        input logic exp_err, input logic [31:0] exp_rdata,
                        input logic [3:0] exp_sel, input logic exp_bus,
                        input logic [31:0] exp_dat);
    logic [31:0] mask;
    for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{exp_sel[i]}};
    sb_q.push_back('{err: exp_err, rdata: exp_rdata});
    bus.req_i      = 1'b1;
    bus.we_i       = we;
    bus.addr_i     = addr;
    bus.size_i     = size;
    bus.unsigned_i = uns;
    bus.wdata_i    = wdata;
    @(posedge clk); #1;
    bus.req_i = 1'b0;
    if (exp_bus) begin
      for (int c = 0; c <= dly; c++) begin
        check({name, "_cyc"}, 32'(bus.cyc_o), 32'd1);
        check({name, "_stb"}, 32'(bus.stb_o), 32'd1);
        check({name, "_we"}, 32'(bus.we_o), 32'(we));
        check({name, "_adr"}, bus.adr_o, {addr[31:2], 2'b00});
        check({name, "_sel"}, 32'(bus.sel_o), 32'(exp_sel));
        if (we) check({name, "_dat"}, bus.dat_o & mask, exp_dat & mask);
        if (c < dly) begin
          bus.req_i  = 1'b1;
          bus.addr_i = 32'h0000_0003;
          @(posedge clk); #1;
        end
      end
      bus.req_i = 1'b0;
      bus.dat_i = rd;
      bus.ack_i = 1'b1;
      bus.err_i = berr;
      @(posedge clk); #1;
      bus.ack_i = 1'b0;
      bus.err_i = 1'b0;
      check({name, "_done"}, 32'(bus.done_o), 32'd1);
      check({name, "_cyc_drop"}, 32'(bus.cyc_o), 32'd0);
    end else begin
      check({name, "_nocyc"}, 32'(bus.cyc_o), 32'd0);
      check({name, "_done"}, 32'(bus.done_o), 32'd1);
    end
    @(posedge clk); #1;
    check({name, "_done_once"}, 32'(bus.done_o), 32'd0);
    check({name, "_idle"}, 32'(bus.busy_o), 32'd0);
  endtask

  initial begin
    rst            = 1'b1;
    bus.req_i      = 1'b0;
    bus.we_i       = 1'b0;
    bus.addr_i     = '0;
    bus.size_i     = 2'b00;
    bus.unsigned_i = 1'b0;
    bus.wdata_i    = '0;
    bus.dat_i      = '0;
    bus.ack_i      = 1'b0;
    bus.err_i      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cyc", 32'(bus.cyc_o), 32'd0);
    check("rst_stb", 32'(bus.stb_o), 32'd0);
    check("rst_we", 32'(bus.we_o), 32'd0);
    check("rst_sel", 32'(bus.sel_o), 32'd0);
    check("rst_done", 32'(bus.done_o), 32'd0);
    check("rst_err", 32'(bus.err_o), 32'd0);
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_rdata", bus.rdata_o, 32'd0);
    rst = 1'b0;

    // Stray acknowledge/error while idle.
    bus.ack_i = 1'b1;
    bus.err_i = 1'b1;
    @(posedge clk); #1;
    bus.ack_i = 1'b0;
    bus.err_i = 1'b0;
    check("stray_busy", 32'(bus.busy_o), 32'd0);
    @(posedge clk); #1;
    check("stray_done", 32'(bus.done_o), 32'd0);

    //     name        we    addr          size   uns   wdata          dat_i          dly berr  err   rdata          sel      bus   dat
    access("ld_sb",    1'b0, 32'h0000_1003, 2'b00, 1'b0, 32'h0,         32'h80FF_FF7F, 0,  1'b0, 1'b0, 32'hFFFF_FF80, 4'b1000, 1'b1, 32'h0);
    access("ld_uh",    1'b0, 32'h0000_2002, 2'b01, 1'b1, 32'h0,         32'hBEEF_1234, 1,  1'b0, 1'b0, 32'h0000_BEEF, 4'b1100, 1'b1, 32'h0);
    access("st_b",     1'b1, 32'h0000_0001, 2'b00, 1'b0, 32'h0000_00AB, 32'hDEAD_BEEF, 5,  1'b0, 1'b0, 32'h0000_BEEF, 4'b0010, 1'b1, 32'h0000_AB00);
    access("mis_w",    1'b0, 32'h0000_0006, 2'b10, 1'b0, 32'h0,         32'h0,         0,  1'b0, 1'b1, 32'h0000_BEEF, 4'b0000, 1'b0, 32'h0);
    access("bus_err",  1'b0, 32'h0000_0010, 2'b10, 1'b0, 32'h0,         32'h1234_5678, 0,  1'b1, 1'b1, 32'h0000_BEEF, 4'b1111, 1'b1, 32'h0);
    access("st_w",     1'b1, 32'h0000_0104, 2'b10, 1'b0, 32'hA1B2_C3D4, 32'h0,         2,  1'b0, 1'b0, 32'h0000_BEEF, 4'b1111, 1'b1, 32'hA1B2_C3D4);
    access("ld_w",     1'b0, 32'h0000_0020, 2'b10, 1'b0, 32'h0,         32'hCAFE_F00D, 0,  1'b0, 1'b0, 32'hCAFE_F00D, 4'b1111, 1'b1, 32'h0);
    access("ld_sh",    1'b0, 32'h0000_0000, 2'b01, 1'b0, 32'h0,         32'h0000_8001, 0,  1'b0, 1'b0, 32'hFFFF_8001, 4'b0011, 1'b1, 32'h0);
    access("st_h",     1'b1, 32'h0000_0002, 2'b01, 1'b0, 32'h1234_5678, 32'h0,         1,  1'b0, 1'b0, 32'hFFFF_8001, 4'b1100, 1'b1, 32'h5678_0000);
    access("mis_h",    1'b0, 32'h0000_0005, 2'b01, 1'b0, 32'h0,         32'h0,         0,  1'b0, 1'b1, 32'hFFFF_8001, 4'b0000, 1'b0, 32'h0);

    // Reset during BUS aborts the access with no response.
    bus.req_i  = 1'b1;
    bus.we_i   = 1'b0;
    bus.addr_i = 32'h0000_0040;
    bus.size_i = 2'b10;
    @(posedge clk); #1;
    bus.req_i = 1'b0;
    check("abort_cyc_before", 32'(bus.cyc_o), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_cyc", 32'(bus.cyc_o), 32'd0);
    check("abort_stb", 32'(bus.stb_o), 32'd0);
    check("abort_done", 32'(bus.done_o), 32'd0);
    check("abort_busy", 32'(bus.busy_o), 32'd0);
    check("abort_rdata", bus.rdata_o, 32'd0);
    @(posedge clk); #1;
    check("abort_no_done", 32'(bus.done_o), 32'd0);

    access("ld_ub",    1'b0, 32'h0000_0001, 2'b00, 1'b1, 32'h0,         32'h0000_A500, 0,  1'b0, 1'b0, 32'h0000_00A5, 4'b0010, 1'b1, 32'h0);

`ifdef WB_MEM_MASTER_TIMEOUT_EN
    begin
      int waited;
      bit seen;
      sb_q.push_back('{err: 1'b1, rdata: 32'h0000_00A5});
      bus.req_i  = 1'b1;
      bus.we_i   = 1'b0;
      bus.addr_i = 32'h0000_0080;
      bus.size_i = 2'b10;
      @(posedge clk); #1;
      bus.req_i = 1'b0;
      waited    = 1;
      seen      = 1'b0;
      while (!seen && waited < int'(TMO) + 10) begin
        if (bus.done_o === 1'b1) seen = 1'b1;
        else begin
          @(posedge clk); #1;
          waited++;
        end
      end
      check("tmo_done_seen", 32'(seen), 32'd1);
      check("tmo_latency", 32'(waited), 32'(TMO + 1));
      @(posedge clk); #1;
    end
`endif

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_drain", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_mem_master.md
WB_MEM_MASTER -- requirements
Module: wb_mem_master

Interface
REQ-001 SHALL have parameter XLEN, default 32, data and address width; only 32 is supported.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, the bus-wait limit used only when WB_MEM_MASTER_TIMEOUT_EN is defined.
REQ-003 SHALL have port clk_i  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports req_i (input, 1) and we_i (input, 1): a CPU access request and its write flag.
REQ-006 SHALL have ports addr_i (input, XLEN), size_i (input, 2: 00 byte, 01 half, 10 word) and unsigned_i (input, 1: zero-extend loads).
REQ-007 SHALL have ports wdata_i (input, XLEN), busy_o (output, 1), done_o (output, 1, one-cycle pulse), err_o (output, 1, valid with done_o) and rdata_o (output, XLEN).
REQ-008 SHALL have Wishbone ports adr_o (output, XLEN), dat_o (output, XLEN), sel_o (output, 4), we_o, cyc_o and stb_o (outputs, 1), and dat_i (input, XLEN), ack_i (input, 1) and err_i (input, 1).

Function
REQ-009 SHALL implement states IDLE, BUS and RESP.
REQ-010 SHALL capture the request in IDLE when req_i=1; busy_o=1 in every state except IDLE.
REQ-011 SHALL detect misalignment as a half access with addr_i[0]=1 or a word access with addr_i[1:0]!=0.
REQ-012 SHALL, on a misaligned request, go IDLE->RESP with err_o=1, start no bus cycle and leave rdata_o unchanged.
REQ-013 SHALL, on an aligned request, go IDLE->BUS and assert cyc_o, stb_o and we_o (registered) from the next cycle.
REQ-014 SHALL drive adr_o={addr[XLEN-1:2],2'b00}.
REQ-015 SHALL drive sel_o = 4'b0001<<addr[1:0] for a byte, 4'b0011<<{addr[1],1'b0} for a half, and 4'b1111 for a word.
REQ-016 SHALL steer write data onto the lanes selected by sel_o; unselected lanes are don't-care.
REQ-017 SHALL hold every Wishbone output stable in BUS until ack_i or err_i is seen.
REQ-018 SHALL, on ack_i in BUS, drop cyc_o and stb_o on the next edge, register the extracted lane (sign- or zero-extended per unsigned_i) into rdata_o on writes-excluded loads, and enter RESP.
REQ-019 SHALL treat err_i in BUS like ack_i but set err_o=1 and leave rdata_o unchanged; if ack_i and err_i are both high, err_i wins.
REQ-020 SHALL pulse done_o for exactly one cycle in RESP, then return to IDLE.
REQ-021 SHALL ignore req_i while busy_o=1.
REQ-022 SHALL give a minimum aligned latency of req_i at cycle 0, stb_o at cycle 1, ack_i at cycle 1 and done_o at cycle 2.
REQ-023 SHALL ignore a stray ack_i or err_i outside BUS.

Reset
REQ-024 SHALL, on rst_i=1, force state IDLE and drive cyc_o, stb_o, we_o, sel_o, done_o, err_o, busy_o and rdata_o to 0.
REQ-025 SHALL, when reset is asserted mid-transaction, drop cyc_o and stb_o at that edge and produce no done_o for the aborted access.

Configuration
REQ-026 SHALL, with WB_MEM_MASTER_TIMEOUT_EN defined, count cycles in BUS and, when TIMEOUT_CYCLES is reached without ack_i or err_i, end the cycle as in REQ-019 with err_o=1; the counter clears on BUS entry.
REQ-027 SHALL, without WB_MEM_MASTER_TIMEOUT_EN, contain no counter and wait in BUS indefinitely.

Structure
REQ-028 SHALL place the size encodings, the state enum and the sel constants in shared package wb_pkg.
REQ-029 SHALL use one combinational sub-module, wb_lane_mux, for sel generation, write lane steering and read extract/extend; the FSM stays in wb_mem_master.

Verification
REQ-030 SHALL cover a signed byte load: addr=0x1003 with dat_i=0x80FF_FF7F gives sel_o=1000, rdata_o=0xFFFF_FF80 and done_o at cycle 2.
REQ-031 SHALL cover an unsigned half load: addr=0x2002 with dat_i=0xBEEF_1234 gives sel_o=1100 and rdata_o=0x0000_BEEF.
REQ-032 SHALL cover a byte store: addr=0x0001 with wdata=0xAB gives we_o=1, sel_o=0010 and dat_o[15:8]=0xAB; ack delayed 5 cycles gives outputs stable for 5 cycles and done_o once.
REQ-033 SHALL cover a misaligned word: addr=0x0006 gives cyc_o never asserted, done_o with err_o=1 at cycle 1, and rdata_o unchanged.
REQ-034 SHALL cover a bus error: err_i and ack_i high together give err_o=1 and rdata_o unchanged.
REQ-035 SHALL cover an abort: rst_i during BUS gives cyc_o=0 next cycle and no done_o; with WB_MEM_MASTER_TIMEOUT_EN and no ack, err_o=1 after TIMEOUT_CYCLES.
